// File: rtl/vga_cfg_pkg.sv
// Shared constants and state type for the VGA colour configuration controller.
package vga_cfg_pkg;

    localparam int          CW_DEF            = 4;
    localparam logic [15:0] DB_CYCLES_DEF     = 16'd25000;
    localparam logic [23:0] REPEAT_DELAY_DEF  = 24'd12500000;
    localparam logic [23:0] REPEAT_PERIOD_DEF = 24'd2500000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, debounce, press pulse, optional auto-repeat.
module btn_debounce
    import vga_cfg_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES     = DB_CYCLES_DEF,
    parameter logic [23:0] REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter logic [23:0] REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);
    logic        s1, s2, level_d, rep_phase, fire;
    logic [15:0] db_cnt;
    logic [23:0] hold_cnt, hold_nxt, hold_tgt;

    // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD.
    assign hold_nxt = hold_cnt + 24'd1;
    assign hold_tgt = rep_phase ? REPEAT_PERIOD : REPEAT_DELAY;
    assign fire     = REPEAT_EN && level && level_d && (hold_nxt == hold_tgt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            level     <= 1'b0;
            level_d   <= 1'b0;
            db_cnt    <= '0;
            pulse     <= 1'b0;
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_CYCLES - 16'd1) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
            level_d <= level;
            pulse   <= (level & ~level_d) | fire;
            if (!(level && level_d)) begin
                hold_cnt  <= '0;
                rep_phase <= 1'b0;
            end else if (fire) begin
                hold_cnt  <= '0;
                rep_phase <= 1'b1;
            end else begin
                hold_cnt  <= hold_nxt;
            end
        end
    end

endmodule

// File: rtl/vga_color_cfg_ctrl.sv
// Button-driven shadow colour registers, committed to the pixel path on Vsync fall.
module vga_color_cfg_ctrl
    import vga_cfg_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES     = DB_CYCLES_DEF,
    parameter logic [23:0] REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter logic [23:0] REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int          CW            = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          but_r,
    input  logic          but_g,
    input  logic          but_b,
    input  logic          but_clr,
    input  logic          vsync,
    output logic [CW-1:0] col_r,
    output logic [CW-1:0] col_g,
    output logic [CW-1:0] col_b,
    output logic          pending,
    output logic          commit_pulse
);
    localparam int NBTN = 4;
    localparam int BCLR = 3;

    logic [NBTN-1:0]    raw, btn_pulse, lvl_unused;
    logic [2:0][CW-1:0] shadow;
    logic               chg_q, vs_s1, vs_s2, vs_q, vs_fall;
    cfg_state_e         state, state_nxt;

    assign raw = {but_clr, but_b, but_g, but_r};

    genvar i;
    generate
        for (i = 0; i < NBTN; i++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES    (DB_CYCLES),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD),
                .REPEAT_EN    (i != BCLR)
            ) u_db (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw[i]),
                .level(lvl_unused[i]),
                .pulse(btn_pulse[i])
            );
        end
    endgenerate

    // chg_q flags an update already folded into shadow; the FSM reacts a cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            chg_q  <= 1'b0;
        end else begin
            chg_q <= |btn_pulse;
            if (btn_pulse[BCLR]) begin
                shadow <= '0;
            end else begin
                for (int c = 0; c < 3; c++)
                    if (btn_pulse[c]) shadow[c] <= shadow[c] + CW'(1);
            end
        end
    end

    // Reset high so releasing reset never looks like a frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_q  <= vs_s2;
        end
    end

    assign vs_fall = vs_q & ~vs_s2;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (chg_q) state_nxt = PENDING;
            PENDING: if (vs_fall) state_nxt = COMMIT;
            COMMIT:  state_nxt = chg_q ? PENDING : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Entering COMMIT latches the pre-update shadow; a same-edge update re-arms PENDING.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            commit_pulse <= 1'b0;
            col_r        <= '0;
            col_g        <= '0;
            col_b        <= '0;
        end else begin
            state        <= state_nxt;
            pending      <= (state_nxt == PENDING);
            commit_pulse <= (state_nxt == COMMIT);
            if (state_nxt == COMMIT) begin
                col_r <= shadow[0];
                col_g <= shadow[1];
                col_b <= shadow[2];
            end
        end
    end

endmodule

// File: tb/tb_vga_color_cfg_ctrl.sv
// Randomized and directed bench for vga_color_cfg_ctrl against a cycle-level behavioural model.
module tb_vga_color_cfg_ctrl;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       but_r = 1'b0, but_g = 1'b0, but_b = 1'b0, but_clr = 1'b0;
    logic       vsync = 1'b1;
    logic [3:0] col_r, col_g, col_b;
    logic       pending, commit_pulse;

    int checks = 0;
    int failures = 0;
    int cp_seen = 0;

    vga_color_cfg_ctrl #(
        .DB_CYCLES    (16'd4),
        .REPEAT_DELAY (24'd20),
        .REPEAT_PERIOD(24'd8),
        .CW           (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .but_r       (but_r),
        .but_g       (but_g),
        .but_b       (but_b),
        .but_clr     (but_clr),
        .vsync       (vsync),
        .col_r       (col_r),
        .col_g       (col_g),
        .col_b       (col_b),
        .pending     (pending),
        .commit_pulse(commit_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: raw samples age two edges, levels follow the run-length rule,
    // pulses are scheduled from the press time, commits snapshot the shadow on Vsync fall.
    int  k;
    bit  bh[4][2];
    bit  vh[3];
    bit  st[4], rose[4], pp[4];
    int  run[4], tp[4];
    int  shadow[3], mcol[3];
    bit  mpend, mcp, chgp;

    task automatic mreset();
        k = 0;
        for (int i = 0; i < 4; i++) begin
            bh[i][0] = 0; bh[i][1] = 0;
            st[i] = 0; rose[i] = 0; pp[i] = 0; run[i] = 0; tp[i] = -1;
        end
        for (int i = 0; i < 3; i++) begin
            vh[i] = 1; shadow[i] = 0; mcol[i] = 0;
        end
        mpend = 0; mcp = 0; chgp = 0;
    endtask

    task automatic mstep();
        bit vf, chg, np[4];
        bit rw[4];
        int e;
        rw[0] = but_r; rw[1] = but_g; rw[2] = but_b; rw[3] = but_clr;
        k++;
        vf  = vh[2] && !vh[1];
        chg = pp[0] | pp[1] | pp[2] | pp[3];
        mcp = mpend && vf;
        if (mcp) for (int c = 0; c < 3; c++) mcol[c] = shadow[c];
        mpend = mpend ? !vf : chgp;
        chgp = chg;
        if (pp[3]) begin
            for (int c = 0; c < 3; c++) shadow[c] = 0;
        end else begin
            for (int c = 0; c < 3; c++) if (pp[c]) shadow[c] = (shadow[c] + 1) % 16;
        end
        for (int i = 0; i < 4; i++) begin
            np[i] = rose[i];
            if (i < 3 && st[i] && tp[i] >= 0 && k > tp[i]) begin
                e = k - tp[i];
                if (e == RD || (e > RD && (e - RD) % RP == 0)) np[i] = 1;
            end
            if (rose[i]) tp[i] = k;
            rose[i] = 0;
            if (bh[i][1] != st[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    st[i]   = !st[i];
                    run[i]  = 0;
                    rose[i] = st[i];
                    if (!st[i]) tp[i] = -1;
                end
            end else begin
                run[i] = 0;
            end
            bh[i][1] = bh[i][0];
            bh[i][0] = rw[i];
        end
        vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vsync;
        for (int i = 0; i < 4; i++) pp[i] = np[i];
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) mreset();
            else mstep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("col_r", col_r, mcol[0]);
            chk("col_g", col_g, mcol[1]);
            chk("col_b", col_b, mcol[2]);
            chk("pending", pending, mpend);
            chk("commit_pulse", commit_pulse, mcp);
            if (commit_pulse === 1'b1) cp_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick(4);
        vsync = 1'b1;
        tick(6);
    endtask

    task automatic press(input bit r, input bit g, input bit b, input bit c, input int hold, input int gap);
        but_r = r; but_g = g; but_b = b; but_clr = c;
        tick(hold);
        but_r = 0; but_g = 0; but_b = 0; but_clr = 0;
        tick(gap);
    endtask

    initial begin
        int cp0;
        tick(3);
        rst = 1'b1;
        tick(2);
        frame();
        frame();
        chk("idle_col_r", col_r, 0);
        chk("idle_pending", pending, 0);
        chk("idle_no_commit", cp_seen, 0);

        // single press, pending appears on edge 9
        but_r = 1'b1;
        tick(8);
        chk("press_pending_e8", pending, 0);
        tick(1);
        chk("press_pending_e9", pending, 1);
        tick(1);
        but_r = 1'b0;
        tick(10);
        cp0 = cp_seen;
        frame();
        chk("press_commit_once", cp_seen - cp0, 1);
        chk("press_col_r", col_r, 1);
        chk("press_col_g", col_g, 0);
        chk("press_pending_clr", pending, 0);

        // glitches then 17 clean presses wrap green to 1
        repeat (3) press(0, 1, 0, 0, 3, 6);
        chk("glitch_pending", pending, 0);
        repeat (17) press(0, 1, 0, 0, 8, 8);
        frame();
        chk("wrap_col_g", col_g, 1);

        // held blue: press + 4 repeats
        press(0, 0, 1, 0, 50, 10);
        frame();
        chk("repeat_col_b", col_b, 5);

        // clear beats a same-cycle increment
        press(1, 0, 0, 0, 8, 8);
        press(1, 0, 0, 0, 8, 8);
        frame();
        chk("pre_clear_col_r", col_r, 3);
        press(1, 0, 0, 1, 8, 10);
        frame();
        chk("clear_col_r", col_r, 0);
        chk("clear_col_g", col_g, 0);
        chk("clear_col_b", col_b, 0);

        // increment lands on the commit edge
        press(1, 0, 0, 0, 8, 10);
        cp0 = cp_seen;
        but_r = 1'b1;
        tick(5);
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        but_r = 1'b0;
        tick(12);
        chk("collide_commit", cp_seen - cp0, 1);
        chk("collide_old_r", col_r, 1);
        chk("collide_pending", pending, 1);
        frame();
        chk("collide_new_r", col_r, 2);

        // reset mid-operation discards pending work
        press(1, 0, 0, 0, 8, 10);
        chk("midrst_pending_before", pending, 1);
        rst = 1'b0;
        #1;
        chk("midrst_col_r", col_r, 0);
        chk("midrst_pending", pending, 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        cp0 = cp_seen;
        frame();
        chk("midrst_no_commit", cp_seen - cp0, 0);
        chk("midrst_col_after", col_r, 0);

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 60; n++) begin
            press($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0), $urandom_range(1, 40), $urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) frame();
        end
        tick(20);
        frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
